arb_xfer_port: RTL and testbench

Downstream data-transfer stage for the 4-way request/grant arbiter. It takes the arbiter's one-hot grants (gnt_0..gnt_3) and the four clients' data streams. Words from the currently granted client go into a small show-ahead FIFO tagged with the source ID, and the FIFO drives a single shared output with a valid/ready handshake. Per-grant burst accounting (word count, done pulse) and a sticky multi-grant error check are included.

---
 rtl/arb_xfer_port.sv | 243 ++++++++++++++++++++++++
 tb/tb_arb_xfer_port.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_xfer_port.sv
// arb_xfer_port
// -------------
// Transfer stage behind the 4-way request/grant arbiter. The client that
// currently holds the grant writes words into a small show-ahead FIFO. Each
// entry is tagged with its source ID. The FIFO head drives one shared output
// port. Every grant is counted as a burst: burst_len and burst_done report the
// word count when the grant ends. A sticky error flag catches non-one-hot
// grants.
//
// Handshake rule (applies to every valid/ready pair in this block):
//   A word moves on a rising edge of clk exactly when valid and ready are both
//   high in the cycle before that edge. valid never depends on ready. The
//   producer holds its data stable while valid is high and ready is low.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   gnt_0..gnt_3                grants from arbiter (one-hot or zero)
//   data_0..data_3              client write data, DATA_W bits
//   valid_0..valid_3            client word valid
//   ready_0..ready_3            word accepted when valid_x && ready_x
//   out_data, out_src           FIFO head data / source ID (0 when empty)
//   out_valid, out_ready        output handshake (out_valid = FIFO non-empty)
//   burst_len                   word count of the last completed grant
//   burst_done                  one-cycle pulse when a grant ends
//   err_multi_gnt               sticky multi-grant error, cleared by reset
//   dbg_state                   current FSM state (0 idle, 1 busy, 2 error)

module arb_xfer_port #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              gnt_2,
  input  logic              gnt_3,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic              valid_3,
  output logic              ready_0,
  output logic              ready_1,
  output logic              ready_2,
  output logic              ready_3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  burst_len,
  output logic              burst_done,
  output logic              err_multi_gnt,
  output logic [1:0]        dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Grant decode
  // ---------------------------------------------------------------------------
  logic [3:0] gnt_vec;
  logic [3:0] valid_vec;
  logic [2:0] gnt_cnt;
  logic       gnt_one;
  logic       gnt_multi;
  logic [1:0] gnt_id;

  assign gnt_vec   = {gnt_3, gnt_2, gnt_1, gnt_0};
  assign valid_vec = {valid_3, valid_2, valid_1, valid_0};
  assign gnt_cnt   = {2'b00, gnt_0} + {2'b00, gnt_1} + {2'b00, gnt_2} + {2'b00, gnt_3};
  assign gnt_one   = (gnt_cnt == 3'd1);
  assign gnt_multi = (gnt_cnt >= 3'd2);

  // gnt_id is only meaningful when gnt_one is set.
  always_comb begin
    gnt_id = 2'd0;
    if (gnt_1) gnt_id = 2'd1;
    if (gnt_2) gnt_id = 2'd2;
    if (gnt_3) gnt_id = 2'd3;
  end

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] head;

  // The MSB of each pointer is a wrap bit. The pointers are full when the
  // addresses match but the wrap bits differ.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // ---------------------------------------------------------------------------
  // FSM state registers (declared here because ready depends on them)
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [1:0]       src_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] burst_len_q;
  logic             burst_done_q;
  logic             err_q;

  // ---------------------------------------------------------------------------
  // Input acceptance
  // ---------------------------------------------------------------------------
  logic             accept_ok;
  logic [3:0]       ready_vec;
  logic             push;
  logic             pop;
  logic [DATA_W-1:0] push_data;

  // A multi-grant cycle is blocked at once, not only from the next cycle when
  // the FSM reaches ST_ERR. This keeps at most one client ready in any cycle.
  // A full FIFO blocks input even if the head pops in the same cycle. Reset
  // blocks everything.
  assign accept_ok = !reset && !fifo_full && (state_q != ST_ERR) && !gnt_multi;
  assign ready_vec = gnt_vec & {4{accept_ok}};
  assign ready_0   = ready_vec[0];
  assign ready_1   = ready_vec[1];
  assign ready_2   = ready_vec[2];
  assign ready_3   = ready_vec[3];

  assign push = |(ready_vec & valid_vec);
  assign pop  = !fifo_empty && out_ready;

  always_comb begin
    push_data = data_0;
    case (gnt_id)
      2'd1:    push_data = data_1;
      2'd2:    push_data = data_2;
      2'd3:    push_data = data_3;
      default: push_data = data_0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage is not reset. Reading is masked by fifo_empty, so stale entries
  // never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {gnt_id, push_data};
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign out_src   = fifo_empty ? 2'd0 : head[EW-1 -: 2];

  // ---------------------------------------------------------------------------
  // Burst accounting FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_load;
  logic [CNT_W-1:0] cnt_step;

  // cnt_load: the counter value at the start of a new burst. It already
  // includes a word accepted in the burst's first granted cycle.
  assign cnt_load = push ? CNT_W'(1) : '0;
  // cnt_step: the counter saturates at all-ones instead of wrapping.
  assign cnt_step = (push && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= 2'd0;
      cnt_q        <= '0;
      burst_len_q  <= '0;
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      if (gnt_multi) begin
        // Any state goes to ST_ERR. The burst that was open is dropped
        // without a done pulse.
        state_q <= ST_ERR;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (gnt_one) begin
              state_q <= ST_BUSY;
              src_q   <= gnt_id;
              cnt_q   <= cnt_load;
            end
          end
          ST_BUSY: begin
            if (!gnt_one) begin
              // All grants are low. The last granted cycle is already
              // counted in cnt_q.
              state_q      <= ST_IDLE;
              burst_done_q <= 1'b1;
              burst_len_q  <= cnt_q;
            end else if (gnt_id != src_q) begin
              // Handover with no idle cycle: close the old burst and open
              // the new one on this edge.
              burst_done_q <= 1'b1;
              burst_len_q  <= cnt_q;
              src_q        <= gnt_id;
              cnt_q        <= cnt_load;
            end else begin
              cnt_q <= cnt_step;
            end
          end
          ST_ERR:  state_q <= ST_ERR;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign burst_len     = burst_len_q;
  assign burst_done    = burst_done_q;
  assign err_multi_gnt = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_arb_xfer_port.sv
module tb_arb_xfer_port;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;
  localparam int CNT_MAX    = 7;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset;
  logic gnt_0, gnt_1, gnt_2, gnt_3;
  logic [DATA_W-1:0] data_0, data_1, data_2, data_3;
  logic valid_0, valid_1, valid_2, valid_3;
  logic ready_0, ready_1, ready_2, ready_3;
  logic [DATA_W-1:0] out_data;
  logic [1:0] out_src;
  logic out_valid;
  logic out_ready;
  logic [CNT_W-1:0] burst_len;
  logic burst_done;
  logic err_multi_gnt;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arb_xfer_port #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2), .gnt_3(gnt_3),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready),
    .burst_len(burst_len), .burst_done(burst_done),
    .err_multi_gnt(err_multi_gnt), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Stimulus state (driven onto the DUT at each negedge)
  // ---------------------------------------------------------------------------
  logic              g_rst;
  logic [3:0]        g_gnt;
  logic [3:0]        g_vld;
  logic [DATA_W-1:0] g_dat [4];
  logic              g_ordy;

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO is an expected queue of {src, data}. A burst is
  // an owner ID (-1 = none) plus a saturating word count.
  // ---------------------------------------------------------------------------
  logic [DATA_W+1:0] exp_q [$];
  int                m_owner;
  int                m_cnt;
  int                m_len;
  logic              m_done;
  logic              m_err;
  logic              m_push;

  int n_checks;
  int n_pass;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_owner = -1;
    m_cnt   = 0;
    m_len   = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock cycle: drive, check the combinational outputs, advance the
  // model across the edge, then check the registered outputs.
  task automatic run_cycle();
    int ng;
    int gid;
    logic [3:0] exp_rdy;
    logic [DATA_W+1:0] hd;
    logic pop;
    @(negedge clk);
    reset = g_rst;
    gnt_0 = g_gnt[0]; gnt_1 = g_gnt[1]; gnt_2 = g_gnt[2]; gnt_3 = g_gnt[3];
    valid_0 = g_vld[0]; valid_1 = g_vld[1]; valid_2 = g_vld[2]; valid_3 = g_vld[3];
    data_0 = g_dat[0]; data_1 = g_dat[1]; data_2 = g_dat[2]; data_3 = g_dat[3];
    out_ready = g_ordy;
    #1;
    ng  = $countones(g_gnt);
    gid = 0;
    for (int i = 0; i < 4; i++) if (g_gnt[i]) gid = i;
    exp_rdy = (!g_rst && !m_err && ng == 1 && exp_q.size() < FIFO_DEPTH) ? g_gnt : 4'b0000;
    hd = (exp_q.size() != 0) ? exp_q[0] : '0;
    check_eq("ready", {28'd0, ready_3, ready_2, ready_1, ready_0}, {28'd0, exp_rdy});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    check_eq("out_data", {24'd0, out_data}, {24'd0, hd[DATA_W-1:0]});
    check_eq("out_src", {30'd0, out_src}, {30'd0, hd[DATA_W+1:DATA_W]});

    @(posedge clk);
    #1;
    m_push = |(exp_rdy & g_vld);
    if (g_rst) begin
      model_reset();
      m_push = 1'b0;
    end else begin
      pop = (exp_q.size() != 0) && g_ordy;
      if (pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({gid[1:0], g_dat[gid]});
      m_done = 1'b0;
      if (ng >= 2) begin
        m_err = 1'b1;
      end else if (!m_err) begin
        if (m_owner >= 0 && (ng == 0 || gid != m_owner)) begin
          m_done  = 1'b1;
          m_len   = m_cnt;
          m_owner = -1;
        end
        if (m_owner < 0 && ng == 1) begin
          m_owner = gid;
          m_cnt   = 0;
        end
        if (m_owner >= 0 && m_push) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
    end
    check_eq("burst_done", {31'd0, burst_done}, {31'd0, m_done});
    check_eq("burst_len", {29'd0, burst_len}, m_len);
    check_eq("err_multi_gnt", {31'd0, err_multi_gnt}, {31'd0, m_err});
  endtask

  task automatic idle_cycles(input int n);
    g_gnt = 4'b0000;
    g_vld = 4'b0000;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  int k;
  int seg_left;
  int r;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    m_push = 1'b0;
    g_rst = 1'b1; g_gnt = 4'b0010; g_vld = 4'b1111; g_ordy = 1'b1;
    for (int i = 0; i < 4; i++) g_dat[i] = 8'hA0 + 8'(i);
    reset = 1'b1;
    gnt_0 = 1'b0; gnt_1 = 1'b1; gnt_2 = 1'b0; gnt_3 = 1'b0;
    valid_0 = 1'b1; valid_1 = 1'b1; valid_2 = 1'b1; valid_3 = 1'b1;
    data_0 = '0; data_1 = '0; data_2 = '0; data_3 = '0;
    out_ready = 1'b1;
    @(posedge clk);

    // Reset held for 2 cycles with gnt_1 and all valids high
    run_cycle();
    run_cycle();
    g_rst = 1'b0;
    idle_cycles(2);

    // Single burst on client 2
    g_ordy = 1'b1;
    g_gnt  = 4'b0100;
    g_vld  = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      g_dat[2] = 8'h10 + 8'(i);
      run_cycle();
    end
    idle_cycles(3);
    check_eq("single_len", {29'd0, burst_len}, 32'd5);

    // Backpressure: 6 words on client 0, sink stalled for the first 8 cycles
    g_gnt  = 4'b0001;
    g_vld  = 4'b0001;
    g_ordy = 1'b0;
    k = 0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      if (c == 8) begin
        check_eq("bp_full_cnt", k, 32'd4);
        g_ordy = 1'b1;
      end
      g_dat[0] = 8'h20 + 8'(k);
      run_cycle();
      if (m_push) k++;
    end
    check_eq("bp_words", k, 32'd6);
    idle_cycles(6);

    // Empty grant on client 3, then immediate handover to client 1
    g_gnt = 4'b1000;
    g_vld = 4'b0000;
    run_cycle();
    run_cycle();
    g_gnt = 4'b0010;
    g_vld = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      g_dat[1] = 8'h30 + 8'(i);
      run_cycle();
    end
    idle_cycles(4);

    // Multi-grant error with 2 words buffered
    g_ordy = 1'b0;
    g_gnt  = 4'b0001;
    g_vld  = 4'b0001;
    g_dat[0] = 8'h41; run_cycle();
    g_dat[0] = 8'h42; run_cycle();
    g_gnt = 4'b0101;
    g_vld = 4'b1111;
    run_cycle();
    g_gnt  = 4'b0001;
    g_ordy = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle();
    check_eq("err_sticky", {31'd0, err_multi_gnt}, 32'd1);
    g_rst = 1'b1; run_cycle();
    g_rst = 1'b0; idle_cycles(2);

    // Saturation: 10 words in one grant with a 3-bit counter
    g_gnt = 4'b0100;
    g_vld = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      g_dat[2] = 8'h50 + 8'(i);
      run_cycle();
    end
    idle_cycles(3);
    check_eq("sat_len", {29'd0, burst_len}, 32'd7);

    // Randomized traffic
    seg_left = 0;
    for (int c = 0; c < 800; c++) begin
      if (seg_left == 0) begin
        r = $urandom_range(0, 39);
        if (r < 6)       g_gnt = 4'b0000;
        else if (r < 39) g_gnt = 4'b0001 << $urandom_range(0, 3);
        else             g_gnt = 4'($urandom_range(0, 15)) | 4'b0011;
        seg_left = $urandom_range(1, 10);
      end
      seg_left--;
      for (int i = 0; i < 4; i++) begin
        g_vld[i] = ($urandom_range(0, 9) < 7);
        g_dat[i] = 8'($urandom_range(0, 255));
      end
      g_ordy = ($urandom_range(0, 9) < 6);
      g_rst  = (m_err && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    g_rst = 1'b0;
    g_ordy = 1'b1;
    idle_cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
